// File: rtl/key_count_scan_ctrl.sv
// key_count_scan_ctrl: debounced short/long key press driving a 2-digit BCD count
// with a time-multiplexed seven-segment display.
module key_count_scan_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int SCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic       key_state,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic [3:0] Q,
    output logic [3:0] Q_tens,
    output logic       CO,
    output logic [1:0] seg_sel,
    output logic [6:0] codeout
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [1:0]    r_sync;
    logic [DW-1:0] r_deb_cnt;
    logic [LW-1:0] r_hold;
    logic [SW-1:0] r_scan_cnt;
    state_t        r_state;
    logic [LW-1:0] w_hold_nxt;
    logic [3:0]    w_next_digit;
    logic [6:0]    w_next_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        w_hold_nxt   = r_hold + 1'b1;
        // seg_sel bit0 high means tens is showing now, so ones comes next
        w_next_digit = seg_sel[0] ? Q : Q_tens;
        w_next_seg   = seg7(w_next_digit);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_deb_cnt <= '0;
            key_state <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], key};
            if (r_sync[1] == key_state)
                r_deb_cnt <= '0;
            else if (r_deb_cnt == DEB_LAST) begin
                key_state <= r_sync[1];
                r_deb_cnt <= '0;
            end else
                r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            CO          <= 1'b0;
            Q           <= 4'd0;
            Q_tens      <= 4'd0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            CO          <= 1'b0;
            case (r_state)
                IDLE: if (!key_state) begin
                    r_state <= HELD;
                    r_hold  <= '0;
                end
                HELD: if (key_state) begin
                    short_pulse <= 1'b1;
                    r_state     <= IDLE;
                    Q           <= (Q == 4'd9) ? 4'd0 : Q + 4'd1;
                    if (Q == 4'd9) begin
                        Q_tens <= (Q_tens == 4'd9) ? 4'd0 : Q_tens + 4'd1;
                        CO     <= (Q_tens == 4'd9);
                    end
                end else if (w_hold_nxt == LONG_LAST) begin
                    long_pulse <= 1'b1;
                    Q          <= 4'd0;
                    Q_tens     <= 4'd0;
                    r_hold     <= '0;
                    r_state    <= LONG;
                end else
                    r_hold <= w_hold_nxt;
                LONG: if (key_state) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            seg_sel    <= 2'b10;
            codeout    <= 7'h3F;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            seg_sel    <= ~seg_sel;
            codeout    <= w_next_seg;
        end else
            r_scan_cnt <= r_scan_cnt + 1'b1;
    end
endmodule

// File: tb/tb_key_count_scan_ctrl.sv
// tb_key_count_scan_ctrl: scoreboard bench for key_count_scan_ctrl with short debounce,
// long-press and scan periods.
module tb_key_count_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       key;
    logic       key_state, short_pulse, long_pulse, CO;
    logic [3:0] Q, Q_tens;
    logic [1:0] seg_sel;
    logic [6:0] codeout;

    typedef struct {
        logic       is_long;
        logic [3:0] q;
        logic [3:0] qt;
        logic       co;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_checks = 0, n_fail = 0;
    int   n_short = 0, n_long = 0, n_co = 0;
    int   ones = 0, tens = 0;
    logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    key_count_scan_ctrl #(.DEB_CYCLES(50), .LONG_CYCLES(500), .SCAN_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .key_state(key_state),
        .short_pulse(short_pulse), .long_pulse(long_pulse), .Q(Q), .Q_tens(Q_tens),
        .CO(CO), .seg_sel(seg_sel), .codeout(codeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_short();
        exp_t e;
        e.co = 1'b0;
        if (ones == 9) begin
            ones = 0;
            if (tens == 9) begin
                tens = 0;
                e.co = 1'b1;
            end else tens++;
        end else ones++;
        e.is_long = 1'b0;
        e.q  = 4'(ones);
        e.qt = 4'(tens);
        sb.push_back(e);
    endtask

    task automatic push_long();
        exp_t e;
        ones = 0;
        tens = 0;
        e.is_long = 1'b1;
        e.q  = 4'd0;
        e.qt = 4'd0;
        e.co = 1'b0;
        sb.push_back(e);
    endtask

    task automatic press_short();
        key = 1'b0;
        wait_n(60);
        key = 1'b1;
        push_short();
        wait_n(70);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_key_state"}, key_state, 1);
        check({tag, "_short"}, short_pulse, 0);
        check({tag, "_long"}, long_pulse, 0);
        check({tag, "_co"}, CO, 0);
        check({tag, "_q"}, Q, 0);
        check({tag, "_qt"}, Q_tens, 0);
        check({tag, "_seg_sel"}, seg_sel, 2'b10);
        check({tag, "_codeout"}, codeout, 7'h3F);
    endtask

    // Scoreboard: every pulse must match the oldest expected press outcome
    always @(negedge clk) begin
        if (CO) n_co++;
        if (reset_n && (short_pulse || long_pulse)) begin
            if (short_pulse) n_short++;
            if (long_pulse) n_long++;
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e_mon = sb.pop_front();
                check("pulse_kind", long_pulse, e_mon.is_long);
                check("pulse_both", short_pulse & long_pulse, 0);
                check("pulse_q", Q, e_mon.q);
                check("pulse_qt", Q_tens, e_mon.qt);
                check("pulse_co", CO, e_mon.co);
            end
        end
    end

    initial begin
        int saved_short;
        logic [1:0] prev_sel;
        int since;
        bit seen_toggle;
        key = 1'b1;
        reset_n = 1'b0;
        wait_n(100);
        check_reset_vals("reset");
        reset_n = 1'b1;
        wait_n(5);

        for (int i = 0; i < 10; i++) begin
            key = ~key;
            wait_n(20);
            check("bounce_key_state", key_state, 1);
        end
        key = 1'b0;
        wait_n(51);
        check("deb_edge51", key_state, 1);
        wait_n(1);
        check("deb_edge52", key_state, 0);
        wait_n(148);
        check("held_q", Q, 0);
        check("held_no_short", n_short, 0);

        key = 1'b1;
        wait_n(10);
        key = 1'b0;
        wait_n(10);
        key = 1'b1;
        push_short();
        wait_n(52);
        check("rel_key_state", key_state, 1);
        check("rel_short_early", short_pulse, 0);
        wait_n(1);
        check("rel_short_pulse", short_pulse, 1);
        check("rel_q", Q, 1);
        wait_n(1);
        check("rel_short_once", short_pulse, 0);
        wait_n(20);
        check("rel_no_long", n_long, 0);

        repeat (98) press_short();
        check("pre_wrap_q", Q, 9);
        check("pre_wrap_qt", Q_tens, 9);
        check("pre_wrap_co_count", n_co, 0);
        press_short();
        check("wrap_q", Q, 0);
        check("wrap_qt", Q_tens, 0);
        check("wrap_co_cycles", n_co, 1);

        repeat (37) press_short();
        check("at37_q", Q, 7);
        check("at37_qt", Q_tens, 3);
        saved_short = n_short;
        key = 1'b0;
        push_long();
        wait_n(52);
        check("long_key_state", key_state, 0);
        wait_n(499);
        check("long_early", long_pulse, 0);
        wait_n(1);
        check("long_pulse", long_pulse, 1);
        check("long_q", Q, 0);
        check("long_qt", Q_tens, 0);
        check("long_co", CO, 0);
        wait_n(248);
        key = 1'b1;
        wait_n(70);
        check("long_rel_no_short", n_short, saved_short);
        check("long_count", n_long, 1);
        check("long_no_co", n_co, 1);

        repeat (42) press_short();
        wait_n(20);
        prev_sel = seg_sel;
        since = 0;
        seen_toggle = 0;
        for (int i = 0; i < 32; i++) begin
            wait_n(1);
            since++;
            if (seg_sel != prev_sel) begin
                if (seen_toggle) check("scan_period", since, 8);
                seen_toggle = 1;
                since = 0;
                prev_sel = seg_sel;
            end
            check("seg_sel_valid", seg_sel == 2'b10 || seg_sel == 2'b01, 1);
            check("codeout", codeout, seg_tab[seg_sel == 2'b10 ? ones : tens]);
        end
        check("scan_toggled", seen_toggle, 1);

        key = 1'b0;
        wait_n(60);
        reset_n = 1'b0;
        wait_n(1);
        check_reset_vals("midheld");
        reset_n = 1'b1;
        ones = 0;
        tens = 0;
        wait_n(51);
        check("post_rst_edge51", key_state, 1);
        wait_n(1);
        check("post_rst_edge52", key_state, 0);
        wait_n(10);
        key = 1'b1;
        push_short();
        wait_n(70);
        check("post_rst_q", Q, 1);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
